// File: rtl/jtframe_sdram_arb_pkg.sv
// jtframe_sdram_arb_pkg: shared state encoding and counter width for the SDRAM arbiter
package jtframe_sdram_arb_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_RDY} state_t;
  localparam int CW = 8;
endpackage

// File: rtl/jtframe_rr_pick.sv
// jtframe_rr_pick: round-robin find-first starting at ptr
module jtframe_rr_pick #(
  parameter int SLOTS = 4,
  parameter int PW = 2
) (
  input  logic [SLOTS-1:0] req,
  input  logic [PW-1:0]    ptr,
  output logic [PW-1:0]    gnt,
  output logic             any
);
  // scan from the far end back to ptr so the slot closest to ptr wins
  always_comb begin
    int j;
    gnt = '0;
    any = |req;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      j = (int'(ptr) + i) % SLOTS;
      if (req[j[PW-1:0]]) gnt = j[PW-1:0];
    end
  end
endmodule

// File: rtl/jtframe_sdram_arb.sv
// jtframe_sdram_arb: round-robin SDRAM read arbiter with a one-entry cache per slot
module jtframe_sdram_arb
  import jtframe_sdram_arb_pkg::*;
#(
  parameter int SLOTS = 4,
  parameter int AW = 22,
  parameter int DW = 32,
  parameter int TOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [SLOTS-1:0]    slot_req,
  input  logic [SLOTS*AW-1:0] slot_addr,
  output logic [SLOTS-1:0]    slot_ok,
  output logic [SLOTS*DW-1:0] slot_dout,
  output logic                sdram_req,
  output logic [AW-1:0]       sdram_addr,
  input  logic                sdram_ack,
  input  logic [DW-1:0]       data_read,
  input  logic                data_rdy,
  input  logic                loop_rst
);
  localparam int PW = SLOTS > 1 ? $clog2(SLOTS) : 1;
  state_t           state;
  logic [PW-1:0]    ptr, gnt, pick;
  logic [CW-1:0]    cnt;
  logic [SLOTS-1:0] valid, miss;
  logic [AW-1:0]    addr [SLOTS];
  logic [AW-1:0]    tag  [SLOTS];
  logic [DW-1:0]    data [SLOTS];
  logic             any, fill;
  for (genvar i = 0; i < SLOTS; i++) begin : g_slot
    assign addr[i] = slot_addr[i*AW +: AW];
    assign miss[i] = slot_req[i] & ~(valid[i] & (tag[i] == addr[i]));
    assign slot_ok[i] = slot_req[i] & valid[i] & (tag[i] == addr[i]);
    assign slot_dout[i*DW +: DW] = data[i];
  end
  jtframe_rr_pick #(.SLOTS(SLOTS), .PW(PW)) u_pick (
    .req(miss),
    .ptr(ptr),
    .gnt(pick),
    .any(any)
  );
  assign fill = data_rdy & (state == WAIT_RDY | (state == WAIT_ACK & sdram_ack));
  // arbitration FSM and cache fill; sdram_addr doubles as the latched fetch address
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
      ptr        <= '0;
      gnt        <= '0;
      cnt        <= '0;
      valid      <= '0;
      tag        <= '{default: '0};
      data       <= '{default: '0};
    end else if (downloading) begin
      state     <= IDLE;
      sdram_req <= 1'b0;
      valid     <= '0;
    end else if (loop_rst) begin
      state     <= IDLE;
      sdram_req <= 1'b0;
    end else begin
      if (fill) begin
        tag[gnt]   <= sdram_addr;
        data[gnt]  <= data_read;
        valid[gnt] <= 1'b1;
      end
      case (state)
        IDLE: if (any) begin
          gnt        <= pick;
          sdram_addr <= addr[pick];
          sdram_req  <= 1'b1;
          ptr        <= pick == PW'(SLOTS - 1) ? '0 : pick + 1'b1;
          state      <= WAIT_ACK;
        end
        WAIT_ACK: if (sdram_ack) begin
          sdram_req <= 1'b0;
          cnt       <= '0;
          state     <= data_rdy ? IDLE : WAIT_RDY;
        end
        WAIT_RDY: begin
          cnt   <= cnt + 1'b1;
          state <= data_rdy || cnt == CW'(TOUT) ? IDLE : WAIT_RDY;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
